conv_pass_sched: RTL
====================

// Module: conv_pass_sched
// PURPOSE
//  Sequences one convolution layer through the shared multi-channel 3x3 filter/adder-tree datapath.
//  Walks the output pixels in raster order and the input-channel groups innermost.
//  Issues one window/weight-bank beat per cycle and accumulates the per-group partial sums.
//  Applies the final clip and (leaky) ReLU, then streams pixels out on a valid/ready port.
//  Sits between the line-buffer/weight-bank fetch logic and the feature-map writer.
// PARAMETERS
//  IMG_W     28  output columns per row (>=1)
//  IMG_H     28  output rows (>=1)
//  N_GRP     4   channel groups per pixel (>=1); datapath covers one group per beat
//  WIDTH     10  signed datapath / output width
//  PIPE_LAT  2   cycles from f_issue to the matching f_psum (>=1)
//  OUT_DEPTH 2   output FIFO entries (>=2)
// PORTS
//  clk        in   1      clock
//  resetn     in   1      asynchronous, active-low reset
//  start      in   1      1-cycle pulse; begins a pass; ignored while busy
//  abort      in   1      synchronous flush to IDLE
//  cfg_clip   in   1      saturate final sum (else keep low WIDTH bits)
//  cfg_relu   in   1      enable ReLU stage
//  cfg_relu_c in   8      negative-side slope, Q0.8 (0 = plain ReLU)
//  win_req    out  1      request window (win_row, win_col, win_grp)
//  win_row    out  clog2(IMG_H)   row of the requested window
//  win_col    out  clog2(IMG_W)   column of the requested window
//  win_grp    out  clog2(N_GRP)   also the weight-bank select
//  win_ack    in   1      fetch logic presents x/w to the datapath this cycle
//  f_issue    out  1      = win_req & win_ack; datapath beat valid
//  f_psum     in   WIDTH  signed group partial sum, PIPE_LAT cycles after f_issue
//  out_valid  out  1      output pixel valid
//  out_ready  in   1      downstream accepts
//  out_data   out  WIDTH  signed result
//  busy       out  1      state != IDLE
//  done       out  1      1-cycle pulse at end of pass
// BEHAVIOUR
//  Reset: state=IDLE. win_req, f_issue, out_valid, busy and done are 0. All counters, the accumulator and the FIFO are cleared.
//  Config is latched on the accepted start; mid-pass cfg_* changes have no effect.
//  FSM:
//   IDLE -start-> RUN.
//   RUN -(last beat issued: row=H-1, col=W-1, grp=N_GRP-1)-> DRAIN.
//   DRAIN -(no beats in flight & FIFO empty)-> DONE.
//   DONE -> IDLE, with done=1 for that one cycle.
//  abort from any state -> IDLE next cycle. It drops in-flight tags, clears the FIFO and accumulator, and does not pulse done.
//  RUN: win_req=1 except when grp=0 and credit=0.
//   credit = OUT_DEPTH - FIFO occupancy - pixels in flight or accumulating. This guarantees every issued pixel has a FIFO slot, so there is no back-pressure into the datapath.
//  On f_issue: grp++. At wrap, grp->0 and col++. At col wrap, col->0 and row++.
//  Valid tag shift register, depth PIPE_LAT. Each tag carries first = (grp==0) and last = (grp==N_GRP-1).
//  Tag out: if first, acc = sext(f_psum); else acc += sext(f_psum). acc width = WIDTH+clog2(N_GRP)+1.
//  Tag out with last: the final value r is computed and pushed into the FIFO in the same cycle.
//   cfg_clip: r = clamp(acc, -2^(WIDTH-1), 2^(WIDTH-1)-1).
//   else:     r = acc[WIDTH-1:0].
//   cfg_relu, r<0:  r = (r*relu_c)>>>8, arithmetic shift, floor.
//   cfg_relu, r>=0: r unchanged.
//  N_GRP=1: first and last are both set on the same tag.
//  FIFO: push and pop in the same cycle are allowed when the FIFO is full or empty-with-push.
//   out_data is stable while out_valid & !out_ready.
//  start while busy: ignored. start and abort together: abort wins.
// STRUCTURE
//  Shared package conv_pkg:
//   state enum {IDLE, RUN, DRAIN, DONE}.
//   clamp and relu functions.
//   WIDTH and the Q0.8 shift constant.
//  One sub-module: conv_out_fifo. It is a synchronous FIFO with parameters DEPTH and WIDTH and a count output that feeds the credit logic.
// TESTING
//  1. IMG 2x2, N_GRP=2, win_ack=1, out_ready=1, psum=+3 per beat.
//     -> 4 outputs of 6, in raster order. done pulses once, 8+PIPE_LAT+~2 cycles after start.
//  2. cfg_clip=1, N_GRP=4, psum=300 each -> out=511. Same stimulus with psum=-300 -> out=-512.
//  3. cfg_relu=1, relu_c=64, final sum -100 -> out=-25. Same with relu_c=0 -> out=0. Same with sum +100 -> out=100.
//  4. out_ready held 0 for 20 cycles.
//     -> at most OUT_DEPTH pixels accepted, win_req stalls at grp=0, no output lost or duplicated, data resumes in order.
//  5. Random win_ack gaps with N_GRP=3.
//     -> the accumulator matches a scoreboard sum per pixel. grp/col/row wrap correctly at the 2x3 image corners.
//  6. abort mid-RUN with 2 beats in flight.
//     -> IDLE next cycle, out_valid=0, no done pulse. A following start produces a clean full pass.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the convolution pass scheduler.
package conv_pkg;

  localparam int WIDTH      = 10;
  localparam int RELU_SHIFT = 8;   // relu slope is Q0.8

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Saturate a signed value into a w-bit two's-complement range.
  function automatic logic signed [31:0] clamp_sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Leaky ReLU: negative inputs scaled by c/256, floored by the arithmetic shift.
  function automatic logic signed [31:0] relu_leaky(input logic signed [31:0] r, input logic [7:0] c);
    logic signed [31:0] p;
    if (r >= 32'sd0) return r;
    p = r * $signed({24'd0, c});
    return p >>> RELU_SHIFT;
  endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Small synchronous output FIFO; count feeds the scheduler's credit logic.
module conv_out_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 10,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop   = pop & (count_q != '0);
  assign do_push  = push & ((count_q != CW'(DEPTH)) | do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign valid    = (count_q != '0);
  assign count    = count_q;

  // Entry storage; head entry holds still until it is popped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/conv_pass_sched.sv
// Convolution pass scheduler: raster walk over output pixels with channel
// groups innermost, partial-sum accumulation, clip/ReLU and output FIFO.
//
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | issuing window/weight beats, gated by output credit
//  DRAIN | all beats issued; waiting for in-flight tags and FIFO to empty
//  DONE  | one-cycle done pulse, then back to IDLE
module conv_pass_sched
  import conv_pkg::*;
#(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int N_GRP     = 4,
  parameter int WIDTH     = conv_pkg::WIDTH,
  parameter int PIPE_LAT  = 2,
  parameter int OUT_DEPTH = 2,
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int CLW   = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int GW    = (N_GRP > 1) ? $clog2(N_GRP) : 1,
  localparam int ACC_W = WIDTH + $clog2(N_GRP) + 1,
  localparam int CW    = $clog2(OUT_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_clip,
  input  logic             cfg_relu,
  input  logic [7:0]       cfg_relu_c,
  output logic             win_req,
  output logic [RW-1:0]    win_row,
  output logic [CLW-1:0]   win_col,
  output logic [GW-1:0]    win_grp,
  input  logic             win_ack,
  output logic             f_issue,
  input  logic [WIDTH-1:0] f_psum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done
);

  state_t state_q, state_d;

  logic [RW-1:0]  row_q;
  logic [CLW-1:0] col_q;
  logic [GW-1:0]  grp_q;

  logic       cfg_clip_q;
  logic       cfg_relu_q;
  logic [7:0] cfg_relu_c_q;

  logic [PIPE_LAT-1:0] tag_v_q;
  logic [PIPE_LAT-1:0] tag_f_q;
  logic [PIPE_LAT-1:0] tag_l_q;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] psum_ext;
  logic signed [31:0]      acc32;
  logic signed [31:0]      r_clip;

  logic [CW-1:0] pend_q;      // pixels issued but not yet pushed into the FIFO
  logic [CW-1:0] fifo_count;
  logic [CW:0]   used;

  logic has_credit, grp_first, grp_last, col_last, row_last, last_beat, start_ok;
  logic tag_out_v, tag_out_f, tag_out_l, push;
  logic [WIDTH-1:0] push_data;

  assign grp_first = (grp_q == '0);
  assign grp_last  = (grp_q == GW'(N_GRP - 1));
  assign col_last  = (col_q == CLW'(IMG_W - 1));
  assign row_last  = (row_q == RW'(IMG_H - 1));
  assign last_beat = grp_last & col_last & row_last;
  assign start_ok  = (state_q == IDLE) & start & ~abort;

  // A new pixel may only begin when a FIFO slot is guaranteed for it.
  assign used       = {1'b0, fifo_count} + {1'b0, pend_q};
  assign has_credit = (used < (CW + 1)'(OUT_DEPTH));

  assign win_req = (state_q == RUN) & ~(grp_first & ~has_credit);
  assign f_issue = win_req & win_ack;
  assign win_row = row_q;
  assign win_col = col_q;
  assign win_grp = grp_q;
  assign busy    = (state_q != IDLE);

  assign tag_out_v = tag_v_q[PIPE_LAT-1];
  assign tag_out_f = tag_f_q[PIPE_LAT-1];
  assign tag_out_l = tag_l_q[PIPE_LAT-1];
  assign push      = tag_out_v & tag_out_l;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and done pulse; abort overrides everything.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (f_issue && last_beat) state_d = DRAIN;
      DRAIN:   if (!(|tag_v_q) && fifo_count == '0) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      done    = 1'b0;
    end
  end

  // Raster walk over (row, col, grp) and config capture at pass start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_q        <= '0;
      col_q        <= '0;
      grp_q        <= '0;
      cfg_clip_q   <= 1'b0;
      cfg_relu_q   <= 1'b0;
      cfg_relu_c_q <= '0;
    end else if (abort) begin
      row_q <= '0;
      col_q <= '0;
      grp_q <= '0;
    end else if (start_ok) begin
      row_q        <= '0;
      col_q        <= '0;
      grp_q        <= '0;
      cfg_clip_q   <= cfg_clip;
      cfg_relu_q   <= cfg_relu;
      cfg_relu_c_q <= cfg_relu_c;
    end else if (f_issue) begin
      if (grp_last) begin
        grp_q <= '0;
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end else begin
        grp_q <= grp_q + 1'b1;
      end
    end
  end

  // Beat tags travel alongside the datapath so each psum is matched on arrival.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_v_q <= '0;
      tag_f_q <= '0;
      tag_l_q <= '0;
    end else if (abort) begin
      tag_v_q <= '0;
      tag_f_q <= '0;
      tag_l_q <= '0;
    end else begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_f_q[i] <= tag_f_q[i-1];
        tag_l_q[i] <= tag_l_q[i-1];
      end
      tag_v_q[0] <= f_issue;
      tag_f_q[0] <= f_issue & grp_first;
      tag_l_q[0] <= f_issue & grp_last;
    end
  end

  // Group accumulation and final clip/ReLU of the completed pixel.
  always_comb begin
    psum_ext = {{(ACC_W - WIDTH){f_psum[WIDTH-1]}}, f_psum};
    acc_sum  = tag_out_f ? psum_ext : acc_q + psum_ext;
    acc32    = {{(32 - ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
    r_clip   = cfg_clip_q ? clamp_sat(acc32, WIDTH)
                          : {{(32 - WIDTH){acc_sum[WIDTH-1]}}, acc_sum[WIDTH-1:0]};
    push_data = cfg_relu_q ? WIDTH'(relu_leaky(r_clip, cfg_relu_c_q)) : WIDTH'(r_clip);
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        acc_q <= '0;
    else if (abort)     acc_q <= '0;
    else if (tag_out_v) acc_q <= acc_sum;
  end

  // Pixels in flight or accumulating: up on a pixel's first beat, down on its push.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q <= '0;
    end else if (abort) begin
      pend_q <= '0;
    end else begin
      case ({f_issue & grp_first, push})
        2'b10:   pend_q <= pend_q + 1'b1;
        2'b01:   pend_q <= pend_q - 1'b1;
        default: pend_q <= pend_q;
      endcase
    end
  end

  conv_out_fifo #(
    .DEPTH(OUT_DEPTH),
    .WIDTH(WIDTH)
  ) u_out_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (abort),
    .push     (push),
    .push_data(push_data),
    .pop      (out_ready),
    .pop_data (out_data),
    .valid    (out_valid),
    .count    (fifo_count)
  );

endmodule
